// File: rtl/dshot_s.sv
// DShot slave endpoint: pulse-width bit decoder, 4-bit CRC check and a small CPU register window.
// Optional watchdog failsafe is compiled in when DSHOT_S_FAILSAFE_EN is defined.
module dshot_s #(
    parameter int unsigned CLK_FREQ     = 16000000,
    parameter int unsigned SPEED        = 600000,
    parameter int unsigned FAILSAFE_CYC = 160000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] addr_i,
    input  logic [3:0]  wstrb_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    input  logic        rx_i,
    output logic [10:0] throttle_o,
    output logic        telem_req_o,
    output logic        frame_strb_o
);

    localparam int unsigned BitCyc = CLK_FREQ / SPEED;
    localparam logic [7:0]  Half   = 8'(BitCyc / 2);
    localparam logic [7:0]  MinHi  = 8'(BitCyc / 8);
    localparam logic [7:0]  Gap    = 8'(2 * BitCyc);

    typedef enum logic [1:0] {StIdle, StHigh, StLow, StCheck} state_e;

    state_e      state_q, state_d;
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    logic        rise, fall;
    logic [7:0]  hi_cnt_q, hi_cnt_d;
    logic [7:0]  lo_cnt_q, lo_cnt_d, lo_inc;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] shift_q, shift_d;
    logic        frm_err, chk;
    logic        crc_ok_w, good_evt, crc_evt;

    logic        ready_q;
    logic [31:0] rdata_q, rd_mux;
    logic [15:0] good_cnt_q, crc_err_cnt_q, frm_err_cnt_q;
    logic [15:0] last_frame_q;
    logic        crc_ok_q, new_q;
    logic [10:0] throttle_q;
    logic        telem_q, frame_strb_q;
    logic        failsafe;

    logic        bus_req, bus_acc, is_wr;
    logic [1:0]  sel;
    logic        clr_good, clr_err, rd_status;
    logic        unused_bus;

    assign unused_bus = ^{wdata_i, addr_i[31:4], addr_i[1:0]};

    // Two-flop synchronizer plus one delay stage for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1_q   <= 1'b0;
            rx_s2_q   <= 1'b0;
            rx_prev_q <= 1'b0;
        end else begin
            rx_s1_q   <= rx_i;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    assign rise   = rx_s2_q & ~rx_prev_q;
    assign fall   = ~rx_s2_q & rx_prev_q;
    assign lo_inc = (lo_cnt_q == 8'hFF) ? lo_cnt_q : lo_cnt_q + 8'd1;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (rise) state_d = StHigh;
            end
            StHigh: begin
                if (fall) begin
                    if (hi_cnt_q < MinHi)         state_d = StIdle;
                    else if (bit_cnt_q == 5'd15)  state_d = StCheck;
                    else                          state_d = StLow;
                end else if (hi_cnt_q == 8'hFF) begin
                    state_d = StIdle;
                end
            end
            StLow: begin
                if (rise)               state_d = StHigh;
                else if (lo_inc >= Gap) state_d = StIdle;
            end
            StCheck: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: counter/shift next values and decode events
    always_comb begin
        hi_cnt_d  = hi_cnt_q;
        lo_cnt_d  = lo_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        frm_err   = 1'b0;
        chk       = 1'b0;
        case (state_q)
            StIdle: begin
                if (rise) begin
                    hi_cnt_d  = 8'd0;
                    bit_cnt_d = 5'd0;
                end
            end
            StHigh: begin
                if (fall) begin
                    if (hi_cnt_q < MinHi) begin
                        frm_err = 1'b1;
                    end else begin
                        shift_d   = {shift_q[14:0], (hi_cnt_q >= Half)};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        lo_cnt_d  = 8'd0;
                    end
                end else if (hi_cnt_q == 8'hFF) begin
                    frm_err = 1'b1;
                end else begin
                    hi_cnt_d = hi_cnt_q + 8'd1;
                end
            end
            StLow: begin
                if (rise) begin
                    hi_cnt_d = 8'd0;
                end else begin
                    lo_cnt_d = lo_inc;
                    if (lo_inc >= Gap) frm_err = 1'b1;
                end
            end
            StCheck: chk = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_cnt_q  <= 8'd0;
            lo_cnt_q  <= 8'd0;
            bit_cnt_q <= 5'd0;
            shift_q   <= 16'd0;
        end else begin
            hi_cnt_q  <= hi_cnt_d;
            lo_cnt_q  <= lo_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    assign crc_ok_w = (shift_q[15:12] ^ shift_q[11:8] ^ shift_q[7:4]) == shift_q[3:0];
    assign good_evt = chk & crc_ok_w;
    assign crc_evt  = chk & ~crc_ok_w;

    // Bus decode: request phase latches rdata, acknowledge phase commits side effects.
    assign sel       = addr_i[3:2];
    assign is_wr     = |wstrb_i;
    assign bus_req   = valid_i & ~ready_q;
    assign bus_acc   = valid_i & ready_q;
    assign clr_good  = bus_acc & is_wr & (sel == 2'd1);
    assign clr_err   = bus_acc & is_wr & (sel == 2'd2);
    assign rd_status = bus_acc & ~is_wr & (sel == 2'd0);

`ifdef DSHOT_S_FAILSAFE_EN
    logic [31:0] wdog_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_q <= 32'd0;
        end else if (good_evt) begin
            wdog_q <= 32'd0;
        end else if (wdog_q < 32'(FAILSAFE_CYC)) begin
            wdog_q <= wdog_q + 32'd1;
        end
    end

    assign failsafe = (wdog_q >= 32'(FAILSAFE_CYC));
`else
    assign failsafe = 1'b0;
`endif

    always_comb begin
        rd_mux = 32'd0;
        unique case (sel)
            2'd0:    rd_mux = {13'd0, failsafe, new_q, crc_ok_q, last_frame_q};
            2'd1:    rd_mux = {16'd0, good_cnt_q};
            2'd2:    rd_mux = {frm_err_cnt_q, crc_err_cnt_q};
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q       <= 1'b0;
            rdata_q       <= 32'd0;
            good_cnt_q    <= 16'd0;
            crc_err_cnt_q <= 16'd0;
            frm_err_cnt_q <= 16'd0;
            last_frame_q  <= 16'd0;
            crc_ok_q      <= 1'b0;
            new_q         <= 1'b0;
            throttle_q    <= 11'd0;
            telem_q       <= 1'b0;
            frame_strb_q  <= 1'b0;
        end else begin
            ready_q      <= bus_req;
            frame_strb_q <= good_evt;
            if (bus_req) rdata_q <= rd_mux;

            // Clearing writes take priority over same-cycle increments.
            if (clr_good)      good_cnt_q <= 16'd0;
            else if (good_evt) good_cnt_q <= good_cnt_q + 16'd1;

            if (clr_err)      crc_err_cnt_q <= 16'd0;
            else if (crc_evt) crc_err_cnt_q <= crc_err_cnt_q + 16'd1;

            if (clr_err)      frm_err_cnt_q <= 16'd0;
            else if (frm_err) frm_err_cnt_q <= frm_err_cnt_q + 16'd1;

            // A new good frame outranks a coincident STATUS read-clear.
            if (good_evt)       new_q <= 1'b1;
            else if (rd_status) new_q <= 1'b0;

            if (chk) begin
                last_frame_q <= shift_q;
                crc_ok_q     <= crc_ok_w;
            end
            if (good_evt) begin
                throttle_q <= shift_q[15:5];
                telem_q    <= shift_q[4];
            end
        end
    end

    assign ready_o      = ready_q;
    assign rdata_o      = rdata_q;
    assign throttle_o   = failsafe ? 11'd0 : throttle_q;
    assign telem_req_o  = failsafe ? 1'b0 : telem_q;
    assign frame_strb_o = frame_strb_q;

endmodule
